// File: rtl/cnn_crop_scheduler.sv
// Runs NUM_CROPS crops of one frame through a single CNN core and returns all results as one bundle.
// Define CNN_WATCHDOG_EN to add a per-crop timeout that stores all-ones and moves on to the next crop.
module cnn_crop_scheduler #(
    parameter int NUM_CROPS   = 5,
    parameter int RESULT_W    = 160,
    parameter int RST_HOLD    = 16,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic [NUM_CROPS-1:0]          crop_ready,
    output logic                          cnn_rst_n,
    output logic                          cnn_ap_start,
    input  logic                          cnn_ap_ready,
    input  logic                          cnn_out_tvalid,
    input  logic [RESULT_W-1:0]           cnn_out_tdata,
    output logic                          cnn_out_tready,
    output logic [$clog2(NUM_CROPS)-1:0]  crop_idx,
    output logic                          res_tvalid,
    input  logic                          res_tready,
    output logic [NUM_CROPS*RESULT_W-1:0] res_tdata,
    output logic                          busy,
    output logic                          timeout_err
);
    localparam int IDX_W  = $clog2(NUM_CROPS);
    localparam int RCNT_W = $clog2(RST_HOLD + 1);

    typedef enum logic [2:0] {RSTH, IDLE, WAIT_CROP, START, WAIT_ACK, WAIT_RES, DONE} state_t;

    state_t                        state_q;
    logic [RCNT_W-1:0]             rcnt_q;
    logic                          rst_n_q, start_q, tready_q, rvalid_q, busy_q;
    logic [IDX_W-1:0]              idx_q;
    logic [NUM_CROPS*RESULT_W-1:0] res_q;
    logic                          running, wd_hit, adv, last_crop;
    logic [RESULT_W-1:0]           slot_d;

    assign running   = state_q inside {START, WAIT_ACK, WAIT_RES};
    assign last_crop = (idx_q == IDX_W'(NUM_CROPS - 1));

`ifdef CNN_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    state_t          wd_st_q;
    logic            to_q;

    // wd_st_q lags state_q by one cycle, so a mismatch marks the first cycle in a new state.
    assign wd_hit = running && (state_q == wd_st_q) && (wd_q == WD_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q    <= '0;
            wd_st_q <= RSTH;
            to_q    <= 1'b0;
        end else begin
            wd_st_q <= state_q;
            if (!running)                wd_q <= '0;
            else if (state_q != wd_st_q) wd_q <= WD_W'(1);
            else                         wd_q <= wd_q + WD_W'(1);
            if (state_q == IDLE && frame_start) to_q <= 1'b0;
            else if (wd_hit)                    to_q <= 1'b1;
        end
    end
    assign timeout_err = to_q;
`else
    assign wd_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // A captured result and a watchdog expiry both close the current crop the same way.
    always_comb begin
        adv    = wd_hit || (state_q == WAIT_RES && cnn_out_tvalid);
        slot_d = (state_q == WAIT_RES && cnn_out_tvalid) ? cnn_out_tdata : '1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RSTH;
            rcnt_q   <= '0;
            rst_n_q  <= 1'b0;
            start_q  <= 1'b0;
            tready_q <= 1'b0;
            idx_q    <= '0;
            rvalid_q <= 1'b0;
            res_q    <= '0;
            busy_q   <= 1'b0;
        end else if (adv) begin
            res_q[int'(idx_q)*RESULT_W +: RESULT_W] <= slot_d;
            start_q  <= 1'b0;
            tready_q <= 1'b0;
            if (last_crop) begin
                state_q  <= DONE;
                rvalid_q <= 1'b1;
            end else begin
                idx_q   <= idx_q + IDX_W'(1);
                state_q <= WAIT_CROP;
            end
        end else begin
            case (state_q)
                RSTH:
                    if (rcnt_q == RCNT_W'(RST_HOLD - 1)) begin
                        rst_n_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        rcnt_q <= rcnt_q + RCNT_W'(1);
                    end
                IDLE:
                    if (frame_start) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_CROP;
                    end
                WAIT_CROP:
                    if (crop_ready[idx_q]) begin
                        start_q <= 1'b1;
                        state_q <= START;
                    end
                START, WAIT_ACK:
                    if (cnn_ap_ready) begin
                        start_q  <= 1'b0;
                        tready_q <= 1'b1;
                        state_q  <= WAIT_RES;
                    end else begin
                        state_q <= WAIT_ACK;
                    end
                DONE:
                    if (res_tready) begin
                        rvalid_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                default: ;
            endcase
        end
    end

    assign cnn_rst_n      = rst_n_q;
    assign cnn_ap_start   = start_q;
    assign cnn_out_tready = tready_q;
    assign crop_idx       = idx_q;
    assign res_tvalid     = rvalid_q;
    assign res_tdata      = res_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_cnn_crop_scheduler.sv
// Directed bench for cnn_crop_scheduler: reset hold, full frames, stalled crop, DONE back-pressure, mid-frame reset.
module tb_cnn_crop_scheduler;
    localparam int N  = 5;
    localparam int RW = 160;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_start = 1'b0;
    logic [N-1:0]      crop_ready = '0;
    logic              cnn_ap_ready = 1'b0;
    logic              cnn_out_tvalid = 1'b0;
    logic [RW-1:0]     cnn_out_tdata = '0;
    logic              res_tready = 1'b0;
    logic              cnn_rst_n, cnn_ap_start, cnn_out_tready, res_tvalid, busy, timeout_err;
    logic [2:0]        crop_idx;
    logic [N*RW-1:0]   res_tdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cnn_crop_scheduler #(.NUM_CROPS(N), .RESULT_W(RW), .RST_HOLD(16), .WDOG_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .crop_ready(crop_ready),
        .cnn_rst_n(cnn_rst_n), .cnn_ap_start(cnn_ap_start), .cnn_ap_ready(cnn_ap_ready),
        .cnn_out_tvalid(cnn_out_tvalid), .cnn_out_tdata(cnn_out_tdata), .cnn_out_tready(cnn_out_tready),
        .crop_idx(crop_idx), .res_tvalid(res_tvalid), .res_tready(res_tready), .res_tdata(res_tdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] slot(input int k);
        return res_tdata[k*RW +: RW];
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rst_n"}, cnn_rst_n, 0);
        chk({tag, "_ap_start"}, cnn_ap_start, 0);
        chk({tag, "_tready"}, cnn_out_tready, 0);
        chk({tag, "_crop_idx"}, crop_idx, 0);
        chk({tag, "_res_tvalid"}, res_tvalid, 0);
        for (int k = 0; k < N; k++) chk($sformatf("%s_slot%0d", tag, k), slot(k), 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout"}, timeout_err, 0);
    endtask

    // Release reset and count cycles until cnn_rst_n rises.
    task automatic release_reset(input string tag);
        int n;
        reset = 1'b0;
        n = 0;
        while (!cnn_rst_n && n < 100) begin tick(); n++; end
        chk({tag, "_hold_cycles"}, n, 16);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("frame_busy", busy, 1);
    endtask

    // Wait for ap_start (checking its latency), optionally stall the ack, then ack.
    task automatic ack_crop(input int k, input int lat, input int ack_dly);
        int n;
        logic held;
        n = 0;
        while (!cnn_ap_start && n < 300) begin tick(); n++; end
        chk($sformatf("start_lat_c%0d", k), n, lat);
        chk($sformatf("crop_idx_c%0d", k), crop_idx, k);
        held = 1'b1;
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            if (!cnn_ap_start) held = 1'b0;
        end
        chk($sformatf("ap_start_held_c%0d", k), held, 1);
        cnn_ap_ready = 1'b1;
        tick();
        cnn_ap_ready = 1'b0;
        chk($sformatf("ap_start_drop_c%0d", k), cnn_ap_start, 0);
        chk($sformatf("tready_on_c%0d", k), cnn_out_tready, 1);
    endtask

    task automatic give_res(input logic [RW-1:0] d);
        cnn_out_tvalid = 1'b1;
        cnn_out_tdata  = d;
        tick();
        cnn_out_tvalid = 1'b0;
        cnn_out_tdata  = '0;
        chk("tready_off", cnn_out_tready, 0);
    endtask

    task automatic accept_bundle();
        res_tready = 1'b1;
        tick();
        res_tready = 1'b0;
        chk("bundle_accepted", res_tvalid, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        logic          stable, bad;
        logic [N*RW-1:0] snap;
        int            n;

        // Reset values and RSTH hold
        tick(); tick();
        chk_reset_vals("por");
        release_reset("por");

        // Frame 1: all crops ready, CNN returns k+1
        crop_ready = 5'b11111;
        pulse_frame();
        chk("f1_idx0", crop_idx, 0);
        for (int k = 0; k < N; k++) begin
            ack_crop(k, 1, 0);
            give_res(RW'(k + 1));
        end
        chk("f1_res_tvalid", res_tvalid, 1);
        for (int k = 0; k < N; k++) chk($sformatf("f1_slot%0d", k), slot(k), RW'(k + 1));

        // DONE back-pressure for 50 cycles with a stray frame_start
        snap = res_tdata;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            frame_start = (i == 10);
            tick();
            if (!res_tvalid || res_tdata !== snap) stable = 1'b0;
        end
        frame_start = 1'b0;
        chk("done_stable", stable, 1);
        chk("done_idx_hold", crop_idx, 4);
        chk("done_busy", busy, 1);
        res_tready  = 1'b1;
        frame_start = 1'b1;
        tick();
        res_tready  = 1'b0;
        frame_start = 1'b0;
        chk("done_exit_tvalid", res_tvalid, 0);
        chk("done_exit_busy", busy, 0);
        tick(); tick();
        chk("frame_start_not_latched", busy, 0);
        chk("no_start_in_idle", cnn_ap_start, 0);

        // Frame 2: crop 2 late by 100 cycles; stray tvalid meanwhile must be ignored
        crop_ready = 5'b11011;
        pulse_frame();
        for (int k = 0; k < 2; k++) begin
            ack_crop(k, 1, 0);
            give_res(RW'(16 + k));
        end
        bad = 1'b0;
        cnn_out_tvalid = 1'b1;
        cnn_out_tdata  = RW'(16'hBAD0);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cnn_ap_start || cnn_out_tready) bad = 1'b1;
        end
        cnn_out_tvalid = 1'b0;
        cnn_out_tdata  = '0;
        chk("stall_no_start", bad, 0);
        chk("stall_idx", crop_idx, 2);
        crop_ready[2] = 1'b1;
        tick();
        chk("late_start_1cyc", cnn_ap_start, 1);
        ack_crop(2, 0, 0);
        give_res(RW'(18));
        for (int k = 3; k < N; k++) begin
            ack_crop(k, 1, 0);
            give_res(RW'(16 + k));
        end
        for (int k = 0; k < N; k++) chk($sformatf("f2_slot%0d", k), slot(k), RW'(16 + k));
        accept_bundle();

        // Frame 3: slow ack on crop 0, crop 3 result never arrives on time
        pulse_frame();
        ack_crop(0, 1, 3);
        give_res(RW'(32));
        for (int k = 1; k < 3; k++) begin
            ack_crop(k, 1, 0);
            give_res(RW'(32 + k));
        end
        ack_crop(3, 1, 0);
        n = 0;
        while (!timeout_err && n < 150) begin tick(); n++; end
`ifdef CNN_WATCHDOG_EN
        chk("wdog_cycles", n, 100);
        chk("wdog_slot3_ones", slot(3), '1);
        chk("wdog_idx_adv", crop_idx, 4);
        ack_crop(4, 1, 0);
        give_res(RW'(36));
        chk("wdog_sticky", timeout_err, 1);
`else
        chk("no_wdog_err", timeout_err, 0);
        chk("no_wdog_waiting", cnn_out_tready, 1);
        chk("no_wdog_idx", crop_idx, 3);
        give_res(RW'(35));
        chk("no_wdog_slot3", slot(3), RW'(35));
        ack_crop(4, 1, 0);
        give_res(RW'(36));
`endif
        chk("f3_slot4", slot(4), RW'(36));
        chk("f3_res_tvalid", res_tvalid, 1);
        accept_bundle();

        // Frame 4: reset while crop 1 is waiting for its result
        pulse_frame();
        chk("err_cleared_on_start", timeout_err, 0);
        ack_crop(0, 1, 0);
        give_res(RW'(48));
        ack_crop(1, 1, 0);
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        tick();
        release_reset("midrst");
        pulse_frame();
        for (int k = 0; k < N; k++) begin
            ack_crop(k, 1, 0);
            give_res(RW'(64 + k));
        end
        for (int k = 0; k < N; k++) chk($sformatf("f5_slot%0d", k), slot(k), RW'(64 + k));
        accept_bundle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cnn_crop_scheduler.md
CNN_CROP_SCHEDULER -- requirements
Module: cnn_crop_scheduler

Interface
REQ-001 SHALL have parameter NUM_CROPS, default 5, number of crops scored per frame (>=2).
REQ-002 SHALL have parameter RESULT_W, default 160, CNN result width in bits.
REQ-003 SHALL have parameter RST_HOLD, default 16, number of cycles cnn_rst_n is held low after reset.
REQ-004 SHALL have parameter WDOG_CYCLES, default 65535, per-crop timeout limit in cycles.
REQ-005 SHALL have port clk, input, 1, clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port frame_start, input, 1, single-cycle pulse that arms one frame.
REQ-008 SHALL have port crop_ready, input, NUM_CROPS, per-crop level that is high once that crop's normalised data is available.
REQ-009 SHALL have port cnn_rst_n, output, 1, active-low CNN reset.
REQ-010 SHALL have port cnn_ap_start, output, 1, CNN start strobe.
REQ-011 SHALL have port cnn_ap_ready, input, 1, CNN accepted start.
REQ-012 SHALL have port cnn_out_tvalid, input, 1, CNN result valid.
REQ-013 SHALL have port cnn_out_tdata, input, RESULT_W, CNN result.
REQ-014 SHALL have port cnn_out_tready, output, 1, result accept.
REQ-015 SHALL have port crop_idx, output, clog2(NUM_CROPS), crop currently scheduled.
REQ-016 SHALL have port res_tvalid, output, 1, frame result bundle valid.
REQ-017 SHALL have port res_tready, input, 1, downstream accepts bundle.
REQ-018 SHALL have port res_tdata, output, NUM_CROPS*RESULT_W, results; crop k occupies bits [k*RESULT_W +: RESULT_W].
REQ-019 SHALL have port busy, output, 1, high in every state except IDLE and RSTH.
REQ-020 SHALL have port timeout_err, output, 1, sticky flag, cleared by the next accepted frame_start.

Function
REQ-021 FSM states SHALL be RSTH, IDLE, WAIT_CROP, START, WAIT_ACK, WAIT_RES, DONE.
REQ-022 RSTH SHALL hold cnn_rst_n=0 for exactly RST_HOLD cycles after reset deasserts, then enter IDLE with cnn_rst_n=1.
REQ-023 IDLE SHALL, on frame_start=1, set crop_idx=0 and enter WAIT_CROP; frame_start in any other state SHALL be ignored.
REQ-024 WAIT_CROP SHALL enter START on the cycle after crop_ready[crop_idx]=1 is sampled.
REQ-025 START SHALL hold cnn_ap_start=1 until cnn_ap_ready=1 is sampled (WAIT_ACK is the same condition, ap_start held); cnn_ap_start SHALL drop on the cycle after ack, then the FSM SHALL enter WAIT_RES.
REQ-026 cnn_out_tready SHALL be 1 only in WAIT_RES; cnn_out_tvalid outside WAIT_RES SHALL be dropped.
REQ-027 In WAIT_RES, on cnn_out_tvalid=1, cnn_out_tdata SHALL be captured into slot crop_idx.
REQ-028 After that capture, if crop_idx<NUM_CROPS-1, crop_idx SHALL increment and the FSM SHALL enter WAIT_CROP; otherwise it SHALL enter DONE.
REQ-029 DONE SHALL assert res_tvalid=1 with res_tdata stable until res_tready=1, then enter IDLE.
REQ-030 Simultaneous res_tready and frame_start in DONE SHALL complete DONE only; frame_start is not latched.
REQ-031 Latency from captured result to next cnn_ap_start SHALL be 2 cycles when crop_ready of the next crop is already high.
REQ-032 crop_idx SHALL never exceed NUM_CROPS-1 and SHALL not wrap within a frame.

Reset
REQ-033 On reset the outputs SHALL be: cnn_rst_n=0, cnn_ap_start=0, cnn_out_tready=0, crop_idx=0, res_tvalid=0, res_tdata=0, busy=0, timeout_err=0, state=RSTH.
REQ-034 Reset mid-frame SHALL abort the frame, discard captured results, and re-run the RSTH sequence.

Configuration
REQ-035 With CNN_WATCHDOG_EN defined, a counter SHALL run in START/WAIT_ACK/WAIT_RES, clear on each state change, and on reaching WDOG_CYCLES SHALL set timeout_err, write all-ones to slot crop_idx, and advance as in REQ-028.
REQ-036 Without CNN_WATCHDOG_EN, no counter SHALL exist, timeout_err SHALL be tied 0, and the FSM SHALL wait indefinitely.

Verification
REQ-037 Reset release -> cnn_rst_n low exactly 16 cycles, then IDLE, busy=0.
REQ-038 NUM_CROPS=5, crop_ready=5'b11111, frame_start, CNN returns value k+1 per crop -> 5 ap_start pulses in order, crop_idx 0..4, res_tdata slot k = k+1, res_tvalid=1.
REQ-039 crop_ready[2] delayed 100 cycles -> no cnn_ap_start during that delay; crop 2 starts 1 cycle after its ready.
REQ-040 res_tready held low 50 cycles in DONE -> res_tvalid and res_tdata stable; frame_start pulses are ignored.
REQ-041 CNN_WATCHDOG_EN, WDOG_CYCLES=100, crop 3 never returns -> timeout_err=1 at cycle 100, slot 3 all-ones, crop 4 scheduled.
REQ-042 reset asserted in WAIT_RES of crop 1 -> all outputs at reset values, RSTH re-run, next frame starts at crop 0.
